// File: rtl/hstl_tristate_bus_arbiter_pkg.sv
// Shared encodings for the HSTL tri-state bus arbiter.
// Imported by the arbiter top and its round-robin picker.
package hstl_tristate_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TURN  = 2'd1,
        ST_DRIVE = 2'd2
    } state_e;

    localparam logic T_HIZ = 1'b1;
    localparam logic T_DRV = 1'b0;

    function automatic int rr_wrap(input int i, input int n);
        return (i >= n) ? i - n : i;
    endfunction

endpackage

// File: rtl/hstl_tristate_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or
// above the pointer, scanning upward with wrap.
module hstl_tristate_bus_arbiter_rr_pick
    import hstl_tristate_bus_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int PW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [PW-1:0]    idx,
    output logic             vld
);

    always_comb begin
        idx = '0;
        vld = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!vld && req[rr_wrap(int'(ptr) + i, N_REQ)]) begin
                vld = 1'b1;
                idx = PW'(rr_wrap(int'(ptr) + i, N_REQ));
            end
        end
    end

endmodule

// File: rtl/hstl_tristate_bus_arbiter.sv
// Round-robin owner of a shared HSTL tri-state bus with Hi-Z
// turnaround, bounded hold and global tri-state override.
module hstl_tristate_bus_arbiter
    import hstl_tristate_bus_arbiter_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int W         = 8,
    parameter int TA_CYCLES = 1,
    parameter int MAX_HOLD  = 16
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [N_REQ-1:0]   REQ,
    input  logic [N_REQ*W-1:0] DIN,
    input  logic               GTS_IN,
    output logic [N_REQ-1:0]   GNT,
    output logic [W-1:0]       O_DATA,
    output logic [W-1:0]       T_OUT,
    output logic               BUSY
);

    localparam int PW = $clog2(N_REQ);
    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [3:0] TA_LOAD =
        (TA_CYCLES > 0) ? 4'(TA_CYCLES - 1) : 4'd0;
    localparam logic [HW-1:0] HOLD_LAST =
        (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;

    state_e            state_q, state_d;
    logic [PW-1:0]     owner_q, owner_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [3:0]        ta_q, ta_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic              hiz_q, hiz_d;

    logic [PW-1:0]     pick_ptr, pick_idx, owner_nxt;
    logic              pick_vld;
    logic [N_REQ-1:0]  pick_oh, own_oh;
    logic              req_own, others, leave;

    assign owner_nxt = (int'(owner_q) == N_REQ - 1) ?
                       '0 : owner_q + 1'b1;

    // While driving, arbitrate as if the pointer had already moved
    // past the owner so a hand-over never re-selects the old owner.
    assign pick_ptr = (state_q == ST_DRIVE) ? owner_nxt : ptr_q;

    hstl_tristate_bus_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_pick (
        .req (REQ),
        .ptr (pick_ptr),
        .idx (pick_idx),
        .vld (pick_vld)
    );

    always_comb begin
        pick_oh           = '0;
        pick_oh[pick_idx] = 1'b1;
        own_oh            = '0;
        own_oh[owner_q]   = 1'b1;
    end

    assign req_own = |(REQ & own_oh);
    assign others  = |(REQ & ~own_oh);
    // >= so a late competitor still forces a yield once the
    // counter has run past the limit during an unbounded hold.
    assign leave   = !req_own ||
                     ((MAX_HOLD > 0) && others && (hold_q >= HOLD_LAST));

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        ta_d    = ta_q;
        hold_d  = hold_q;
        gnt_d   = gnt_q;
        hiz_d   = hiz_q;

        case (state_q)
            ST_IDLE: begin
                gnt_d  = '0;
                hiz_d  = T_HIZ;
                ta_d   = '0;
                hold_d = '0;
                if (pick_vld) begin
                    owner_d = pick_idx;
                    if (TA_CYCLES > 0) begin
                        state_d = ST_TURN;
                        ta_d    = TA_LOAD;
                    end else begin
                        state_d = ST_DRIVE;
                        gnt_d   = pick_oh;
                        hiz_d   = T_DRV;
                    end
                end
            end

            ST_TURN: begin
                gnt_d = '0;
                hiz_d = T_HIZ;
                if (ta_q != 4'd0) begin
                    ta_d = ta_q - 4'd1;
                end else if (req_own) begin
                    state_d = ST_DRIVE;
                    gnt_d   = own_oh;
                    hiz_d   = T_DRV;
                    hold_d  = '0;
                end else if (pick_vld) begin
                    state_d = ST_DRIVE;
                    owner_d = pick_idx;
                    gnt_d   = pick_oh;
                    hiz_d   = T_DRV;
                    hold_d  = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_DRIVE: begin
                hold_d = (hold_q == '1) ? hold_q : hold_q + 1'b1;
                if (leave) begin
                    ptr_d  = owner_nxt;
                    hold_d = '0;
                    gnt_d  = '0;
                    hiz_d  = T_HIZ;
                    if (pick_vld) owner_d = pick_idx;
                    if (TA_CYCLES > 0) begin
                        state_d = ST_TURN;
                        ta_d    = TA_LOAD;
                    end else if (pick_vld) begin
                        state_d = ST_DRIVE;
                        gnt_d   = pick_oh;
                        hiz_d   = T_DRV;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                hiz_d   = T_HIZ;
                ta_d    = '0;
                hold_d  = '0;
            end
        endcase

        if (GTS_IN) begin
            state_d = ST_IDLE;
            owner_d = owner_q;
            ptr_d   = ptr_q;
            gnt_d   = '0;
            hiz_d   = T_HIZ;
            ta_d    = '0;
            hold_d  = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            ta_q    <= '0;
            hold_q  <= '0;
            gnt_q   <= '0;
            hiz_q   <= T_HIZ;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            ta_q    <= ta_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            hiz_q   <= hiz_d;
        end
    end

    assign GNT    = gnt_q;
    assign T_OUT  = {W{hiz_q | GTS_IN}};
    assign BUSY   = (state_q != ST_IDLE);
    assign O_DATA = (state_q == ST_DRIVE) ?
                    DIN[int'(owner_q)*W +: W] : '0;

endmodule
